psum_acc_drain: RTL
===================

Name: psum_acc_drain

Overview:
- Downstream neighbour of the output FIFO; drains the FIFO's partial-sum rows (one row = col lanes of psum_bw).
- Accumulates each row across nkp kernel positions into an internal per-pixel accumulator bank.
- After the last kernel position, streams the finished rows out over a valid/ready port to the psum SRAM writer.

Parameters:
- col, 8, number of lanes per row (matches array column count)
- psum_bw, 16, signed partial-sum width per lane
- depth, 16, max output pixels held in the accumulator bank (power of 2)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  one-cycle pulse launching a job
- npix  input  $clog2(depth)+1  pixels per kernel position; valid range 1..depth
- nkp  input  4  kernel positions to accumulate; valid range 1..15
- ofifo_valid  input  1  output FIFO holds at least one row
- ofifo_out  input  col*psum_bw  FIFO head row, lane i at [(i+1)*psum_bw-1:i*psum_bw]
- ofifo_rd  output  1  pop FIFO head this cycle
- out_data  output  col*psum_bw  finished row
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- busy  output  1  job in progress (state != IDLE)
- done  output  1  one-cycle pulse at job end

Behaviour:
- Reset (reset==0, async):
  - state=IDLE; pix=0, kp=0.
  - ofifo_rd=0, out_valid=0, out_data=0, busy=0, done=0.
  - Accumulator bank contents undefined.
  - Reset mid-job abandons the job immediately; no partial output is emitted.
- FIFO is show-ahead: ofifo_out is valid in the same cycle as ofifo_valid; a pop takes effect at the clock edge where ofifo_rd=1.
- FSM states: IDLE, ACC, OUT, DONE.
- IDLE:
  - On start with 1<=npix<=depth and nkp!=0: latch npix/nkp, pix=0, kp=0, go to ACC.
  - Out-of-range start is ignored; stay IDLE, done not pulsed.
- ACC:
  - ofifo_rd = ofifo_valid (combinational, only in ACC); no read when FIFO empty.
  - Per pop, per lane: if kp==0, bank[pix]=ofifo_out; else bank[pix]=sat(bank[pix]+ofifo_out).
  - sat = signed saturating add clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - pix increments; at pix==npix-1 it wraps to 0 and kp increments.
  - The pop with kp==nkp-1 and pix==npix-1 moves to OUT with pix=0.
- OUT:
  - out_valid=1; out_data=f(bank[pix]), registered (combinational read of the bank is permitted).
  - out_data stays stable while out_valid && !out_ready.
  - On out_valid && out_ready: pix++. The handshake at pix==npix-1 moves to DONE and drops out_valid next cycle.
  - ofifo_rd=0 throughout OUT.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in the DONE→IDLE cycle after.
- start asserted while busy is ignored.
- npix=1 with nkp=1: single pop, single output.
- Latency: first out_valid appears 1 cycle after the final pop.

Optional Feature:
- Macro: PSUM_RELU_EN.
- Defined: f(x) = max(x,0) per lane, applied at output only; the bank keeps signed values.
- Undefined: f(x)=x; raw signed sums are output.

Test Plan:
- npix=2, nkp=3; FIFO rows lane0 = 1,2,3,4,5,6 (other lanes 0) -> outputs lane0 = 9 (1+3+5), then 12 (2+4+6); done pulses once; exactly 6 pops.
- psum_bw=16; nkp=2, npix=1; lane3 = 30000 then 10000 -> out lane3 = 32767. Repeat with -30000, -10000 -> -32768.
- out_ready held low 5 cycles during the first output -> out_data stable and out_valid held; no pix advance; then both rows delivered in order.
- FIFO ofifo_valid toggling 1/0 every cycle -> ofifo_rd only when ofifo_valid=1; sums identical to the uninterrupted case.
- PSUM_RELU_EN defined, nkp=1, lane0 = -5, lane1 = 7 -> out 0, 7. Undefined -> -5, 7.
- start with npix=0, npix=depth+1, or nkp=0 -> stays IDLE, no pops. Reset pulled low mid-ACC -> all outputs 0 next sample. A fresh job then runs correctly.

Source files
------------

// File: rtl/psum_acc_drain.sv
// Drains partial-sum rows from the output FIFO and accumulates each pixel over nkp kernel
// positions, then streams the finished rows out. Define PSUM_RELU_EN to clamp negative lanes at the output.
module psum_acc_drain #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(depth):0]     npix,
  input  logic [3:0]                 nkp,
  input  logic                       ofifo_valid,
  input  logic [col*psum_bw-1:0]     ofifo_out,
  output logic                       ofifo_rd,
  output logic [col*psum_bw-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(depth);
  localparam int PW = $clog2(depth) + 1;
  localparam int RW = col * psum_bw;

  typedef enum logic [1:0] {IDLE, ACC, OUT, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pix_q, pix_d;
  logic [3:0]      kp_q, kp_d;
  logic [PW-1:0]   npix_q, npix_d;
  logic [3:0]      nkp_q, nkp_d;
  logic [RW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [RW-1:0]   bank_q [depth];

  logic [RW-1:0]   rd_row_s, acc_row_s;
  logic            bank_we_s, last_pix_s, last_kp_s, start_ok_s, pop_s, hs_s;

  function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                 input logic [psum_bw-1:0] b);
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1]) begin
      sat_add = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    end else begin
      sat_add = s[psum_bw-1:0];
    end
  endfunction

  function automatic logic [RW-1:0] out_map(input logic [RW-1:0] r);
    logic [RW-1:0] m;
    m = r;
`ifdef PSUM_RELU_EN
    for (int i = 0; i < col; i++) begin
      if (r[i*psum_bw + psum_bw - 1]) begin
        m[i*psum_bw +: psum_bw] = {psum_bw{1'b0}};
      end else begin
        m[i*psum_bw +: psum_bw] = r[i*psum_bw +: psum_bw];
      end
    end
`endif
    return m;
  endfunction

  assign pop_s      = (state_q == ACC) && ofifo_valid;
  assign hs_s       = out_valid_q && out_ready;
  assign last_pix_s = ({1'b0, pix_q} == (npix_q - PW'(1)));
  assign last_kp_s  = (kp_q == (nkp_q - 4'd1));
  assign start_ok_s = start && (npix != {PW{1'b0}}) && (npix <= PW'(depth)) && (nkp != 4'd0);
  assign rd_row_s   = bank_q[pix_q];

  assign ofifo_rd   = pop_s;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Per-lane first-write or saturating accumulate of the FIFO head into the current pixel.
  always_comb begin
    acc_row_s = {RW{1'b0}};
    for (int i = 0; i < col; i++) begin
      if (kp_q == 4'd0) begin
        acc_row_s[i*psum_bw +: psum_bw] = ofifo_out[i*psum_bw +: psum_bw];
      end else begin
        acc_row_s[i*psum_bw +: psum_bw] = sat_add(rd_row_s[i*psum_bw +: psum_bw],
                                                  ofifo_out[i*psum_bw +: psum_bw]);
      end
    end
  end

  // Next-state, counters and output-row selection.
  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    kp_d       = kp_q;
    npix_d     = npix_q;
    nkp_d      = nkp_q;
    out_data_d = out_data_q;
    bank_we_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok_s) begin
          npix_d  = npix;
          nkp_d   = nkp;
          pix_d   = {AW{1'b0}};
          kp_d    = 4'd0;
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (pop_s) begin
          bank_we_s = 1'b1;
          if (last_pix_s) begin
            pix_d = {AW{1'b0}};
            if (last_kp_s) begin
              // Row 0 is still being written this cycle when there is only one pixel.
              state_d    = OUT;
              out_data_d = out_map((npix_q == PW'(1)) ? acc_row_s : bank_q[{AW{1'b0}}]);
            end else begin
              kp_d = kp_q + 4'd1;
            end
          end else begin
            pix_d = pix_q + AW'(1);
          end
        end else begin
          state_d = ACC;
        end
      end
      OUT: begin
        if (hs_s) begin
          if (last_pix_s) begin
            state_d    = DONE;
            out_data_d = {RW{1'b0}};
          end else begin
            pix_d      = pix_q + AW'(1);
            out_data_d = out_map(bank_q[pix_q + AW'(1)]);
          end
        end else begin
          state_d = OUT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == OUT);
    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pix_q       <= {AW{1'b0}};
      kp_q        <= 4'd0;
      npix_q      <= {PW{1'b0}};
      nkp_q       <= 4'd0;
      out_data_q  <= {RW{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      kp_q        <= kp_d;
      npix_q      <= npix_d;
      nkp_q       <= nkp_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Accumulator bank; contents are don't-care until written by a job.
  always_ff @(posedge clk) begin
    if (bank_we_s) begin
      bank_q[pix_q] <= acc_row_s;
    end
  end

endmodule
